pipelined_csel_adder: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor. Splits WIDTH-bit operands into

---
 rtl/pipelined_csel_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_csel_adder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: pipelined carry-select adder/subtractor on a valid/ready
// stream. Operands are split into WIDTH/BLOCK blocks, one block resolved per stage.
//   clk, rst_n (async, active low)
//   in_valid/in_ready, a, b, cin, sub : operand side (sub=1 -> a-b, cin ignored)
//   out_valid/out_ready, sum, cout, ovf : result side, all registered
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_bad_cfg
        $fatal(1, "pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
    end

    logic             en;
    logic             acc;
    logic             ci;
    logic [WIDTH-1:0] bp;

    // Enable is global: a stalled output freezes every stage, bubbles included.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign acc      = in_valid & en;
    assign bp       = sub ? ~b : b;
    assign ci       = sub | cin;

    for (genvar k = 1; k <= NBLK; k++) begin : g_stg
        logic [BLOCK-1:0]   xa;
        logic [BLOCK-1:0]   xb;
        logic               xc;
        logic               v_d;
        logic               v_q;
        logic               c_q;
        logic [BLOCK:0]     r0;
        logic [BLOCK:0]     r1;
        logic [BLOCK:0]     rs;
        logic [k*BLOCK-1:0] s_d;
        logic [k*BLOCK-1:0] s_q;

        if (k == 1) begin : g_src
            assign xa  = a[BLOCK-1:0];
            assign xb  = bp[BLOCK-1:0];
            assign xc  = ci;
            assign v_d = acc;
            assign s_d = rs[BLOCK-1:0];
        end else begin : g_src
            assign xa  = g_stg[k-1].g_up.ua_q[BLOCK-1:0];
            assign xb  = g_stg[k-1].g_up.ub_q[BLOCK-1:0];
            assign xc  = g_stg[k-1].c_q;
            assign v_d = g_stg[k-1].v_q;
            assign s_d = {rs[BLOCK-1:0], g_stg[k-1].s_q};
        end

        // Both carry hypotheses, resolved by the registered carry from below.
        assign r0 = {1'b0, xa} + {1'b0, xb};
        assign r1 = r0 + (BLOCK+1)'(1);
        assign rs = xc ? r1 : r0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                c_q <= rs[BLOCK];
                s_q <= s_d;
            end
        end

        if (k < NBLK) begin : g_up
            logic [WIDTH-k*BLOCK-1:0] ua_d;
            logic [WIDTH-k*BLOCK-1:0] ub_d;
            logic [WIDTH-k*BLOCK-1:0] ua_q;
            logic [WIDTH-k*BLOCK-1:0] ub_q;

            if (k == 1) begin : g_in
                assign ua_d = a[WIDTH-1:BLOCK];
                assign ub_d = bp[WIDTH-1:BLOCK];
            end else begin : g_in
                assign ua_d = g_stg[k-1].g_up.ua_q[WIDTH-(k-1)*BLOCK-1:BLOCK];
                assign ub_d = g_stg[k-1].g_up.ub_q[WIDTH-(k-1)*BLOCK-1:BLOCK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ua_q <= '0;
                    ub_q <= '0;
                end else if (en) begin
                    ua_q <= ua_d;
                    ub_q <= ub_d;
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // The top block carries the sign bits of A and B'.
            assign ovf_d = (xa[BLOCK-1] == xb[BLOCK-1]) &
                           (rs[BLOCK-1] != xa[BLOCK-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stg[NBLK].v_q;
    assign sum       = g_stg[NBLK].s_q;
    assign cout      = g_stg[NBLK].c_q;
    assign ovf       = g_stg[NBLK].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: directed vector table plus stream, stall, reset
// and single-stage sequences for pipelined_csel_adder.
module tb_pipelined_csel_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    logic         iv4, ir4, ci4, sb4, ov4, or4, co4, of4;
    logic [3:0]   a4, b4, s4;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_csel_adder #(.WIDTH(4), .BLOCK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(ci4), .sub(sb4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .ovf(of4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {ovf, cout, sum} from plain arithmetic
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c, input logic s);
        logic [15:0] yp;
        logic [16:0] r;
        logic        o;
        yp = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yp} + {16'd0, s | c};
        o  = (x[15] == yp[15]) && (r[15] != x[15]);
        return {o, r};
    endfunction

    task automatic run_stream(input int nops, input bit rnd);
        logic [17:0] q[$];
        logic [17:0] exp;
        logic [3:0]  pat;
        logic [15:0] ps;
        logic        pco, pov, stalled;
        int          issued, cyc;
        pat     = 4'b1001;
        issued  = 0;
        cyc     = 0;
        stalled = 1'b0;
        ps      = '0;
        pco     = 1'b0;
        pov     = 1'b0;
        while ((issued < nops || q.size() != 0) && cyc < 5000) begin
            if (stalled)
                chk("stall_hold", {13'd0, out_valid, ovf, cout, sum},
                    {13'd0, 1'b1, pov, pco, ps});
            if (issued < nops)
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            else
                in_valid = 1'b0;
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
            #1;
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    chk("stream_result", {14'd0, ovf, cout, sum}, {14'd0, exp});
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                issued++;
            end
            stalled = out_valid && !out_ready;
            ps      = sum;
            pco     = cout;
            pov     = ovf;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 5000)
            chk("stream_timeout", 32'(cyc), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[6] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[8] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[9] = '{16'h00FF, 16'h0001, 1'b1, 1'b1, 16'h00FE, 1'b1, 1'b0};

        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; ci4 = 1'b0; sb4 = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_out", {28'd0, out_valid, cout, ovf, in_ready}, 32'h1);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst", {11'd0, out_valid, cout, ovf, in_ready, sum}, 32'h10000);

        // directed table, one op at a time
        for (int i = 0; i < 10; i++) begin
            a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_result", i), {14'd0, ovf, cout, sum},
                {14'd0, vt[i].ov, vt[i].co, vt[i].s});
            step();
        end

        // single-block instance: latency 1
        a4 = 4'hF; b4 = 4'h1; iv4 = 1'b1;
        step();
        chk("w4_allones", {25'd0, ov4, of4, co4, s4}, {25'd0, 1'b1, 1'b0, 1'b1, 4'h0});
        a4 = 4'h7; b4 = 4'h1;
        step();
        iv4 = 1'b0;
        chk("w4_ovf", {25'd0, ov4, of4, co4, s4}, {25'd0, 1'b1, 1'b1, 1'b0, 4'h8});
        a4 = 4'h3; b4 = 4'h5; sb4 = 1'b1;
        iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        chk("w4_sub", {25'd0, ov4, of4, co4, s4}, {25'd0, 1'b1, 1'b0, 1'b0, 4'hE});
        step();

        // back-to-back with out_ready 1,0,0,1
        run_stream(8, 1'b0);
        // random valid/ready
        run_stream(300, 1'b1);

        // async reset with ops in flight
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(16'h0101 * (i + 1)); b = 16'h0011; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {12'd0, out_valid, cout, ovf, 1'b0, sum}, 32'd0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("no_resurrect", {31'd0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
